// File: rtl/branch_predict_unit.sv
// Branch history table / target buffer with EX-stage mispredict detection,
// PC redirect and flush control, post-redirect squash window and statistics.
module branch_predict_unit #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned IDX_BITS      = 4,
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_actual_taken,
    input  logic [XLEN-1:0]   ex_actual_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              mux_to_pc,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              IF_Flush,
    output logic              ID_Flush,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned SQ_W    = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

    typedef enum logic {RUN, SQUASH} state_e;

    state_e               state_q, state_d;
    logic [SQ_W-1:0]      sq_cnt_q, sq_cnt_d;
    logic [1:0]           ctr_q [ENTRIES];
    logic [1:0]           ctr_d [ENTRIES];
    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [XLEN-1:0]      tgt_q [ENTRIES];
    logic [XLEN-1:0]      tgt_d [ENTRIES];
    logic [CNT_W-1:0]     branch_count_q, branch_count_d;
    logic [CNT_W-1:0]     mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0]  if_idx;
    logic [IDX_BITS-1:0]  ex_idx;
    logic                 resolve_c;
    logic                 mispredict_c;
    logic [XLEN-IDX_BITS-1:0] unused_if_pc;

    assign if_idx       = if_pc[IDX_BITS+1:2];
    assign ex_idx       = ex_pc[IDX_BITS+1:2];
    assign unused_if_pc = {if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

    // Read-before-write: prediction always reflects the registered table.
    assign pred_taken  = valid_q[if_idx] & ctr_q[if_idx][1];
    assign pred_target = tgt_q[if_idx];

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    // Resolve/mispredict detection and zero-latency redirect outputs.
    always_comb begin
        resolve_c    = ex_valid & ex_is_branch & (state_q == RUN) & reset_n;
        mispredict_c = resolve_c &
                       ((ex_actual_taken != ex_pred_taken) |
                        (ex_actual_taken & ex_pred_taken & (ex_pred_target != ex_actual_target)));
        mux_to_pc    = mispredict_c;
        IF_Flush     = mispredict_c;
        ID_Flush     = mispredict_c;
        redirect_pc  = '0;
        if (mispredict_c) begin
            redirect_pc = ex_actual_taken ? ex_actual_target : (ex_pc + XLEN'(4));
        end
    end

    // Table and statistics next-state.
    always_comb begin
        ctr_d              = ctr_q;
        valid_d            = valid_q;
        tgt_d              = tgt_q;
        branch_count_d     = branch_count_q + CNT_W'(resolve_c);
        mispredict_count_d = mispredict_count_q + CNT_W'(mispredict_c);
        if (resolve_c) begin
            if (ex_actual_taken) begin
                ctr_d[ex_idx]   = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : (ctr_q[ex_idx] + 2'd1);
                valid_d[ex_idx] = 1'b1;
                tgt_d[ex_idx]   = ex_actual_target;
            end else begin
                ctr_d[ex_idx]   = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : (ctr_q[ex_idx] - 2'd1);
            end
        end
    end

    // Squash-window FSM next-state.
    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            RUN: begin
                if (mispredict_c && (SQUASH_CYCLES > 0)) begin
                    state_d  = SQUASH;
                    sq_cnt_d = SQ_W'(SQUASH_CYCLES);
                end
            end
            SQUASH: begin
                sq_cnt_d = sq_cnt_q - SQ_W'(1);
                if (sq_cnt_q <= SQ_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = RUN;
                sq_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= RUN;
            sq_cnt_q           <= '0;
            valid_q            <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
                tgt_q[i] <= '0;
            end
        end else begin
            state_q            <= state_d;
            sq_cnt_q           <= sq_cnt_d;
            valid_q            <= valid_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            ctr_q              <= ctr_d;
            tgt_q              <= tgt_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench for branch_predict_unit: stimulus pushes the
// hand-computed expected response per cycle, a negedge monitor pops and compares.
module tb_branch_predict_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_actual_taken;
    logic [31:0] ex_actual_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mux_to_pc;
    logic [31:0] redirect_pc;
    logic        IF_Flush;
    logic        ID_Flush;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predict_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_actual_taken  (ex_actual_taken),
        .ex_actual_target (ex_actual_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mux_to_pc        (mux_to_pc),
        .redirect_pc      (redirect_pc),
        .IF_Flush         (IF_Flush),
        .ID_Flush         (ID_Flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        mux;
        logic [31:0] red;
        logic [31:0] bc;
        logic [31:0] mc;
        logic        pt;
        logic [31:0] ptgt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h @%0t", nm, field, act, req, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "mux_to_pc",   32'(mux_to_pc),  32'(e.mux));
            chk(nm, "IF_Flush",    32'(IF_Flush),   32'(e.mux));
            chk(nm, "ID_Flush",    32'(ID_Flush),   32'(e.mux));
            chk(nm, "redirect_pc", redirect_pc,     e.red);
            chk(nm, "branch_cnt",  branch_count,    e.bc);
            chk(nm, "mispred_cnt", mispredict_count, e.mc);
            chk(nm, "pred_taken",  32'(pred_taken), 32'(e.pt));
            chk(nm, "pred_target", pred_target,     e.ptgt);
        end
    end

    task automatic drive(input logic v, input logic br, input logic [31:0] pc, input logic at,
                         input logic [31:0] atgt, input logic pt, input logic [31:0] ptgt,
                         input logic [31:0] ifpc);
        ex_valid         = v;
        ex_is_branch     = br;
        ex_pc            = pc;
        ex_actual_taken  = at;
        ex_actual_target = atgt;
        ex_pred_taken    = pt;
        ex_pred_target   = ptgt;
        if_pc            = ifpc;
    endtask

    task automatic expect_push(input string nm, input logic emux, input logic [31:0] ered,
                               input int ebc, input int emc, input logic ept, input logic [31:0] eptgt);
        exp_t e;
        e.mux  = emux;
        e.red  = ered;
        e.bc   = 32'(ebc);
        e.mc   = 32'(emc);
        e.pt   = ept;
        e.ptgt = eptgt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input string nm, input logic v, input logic br, input logic [31:0] pc,
                        input logic at, input logic [31:0] atgt, input logic pt, input logic [31:0] ptgt,
                        input logic [31:0] ifpc, input logic emux, input logic [31:0] ered,
                        input int ebc, input int emc, input logic ept, input logic [31:0] eptgt);
        @(posedge clk);
        #1;
        drive(v, br, pc, at, atgt, pt, ptgt, ifpc);
        expect_push(nm, emux, ered, ebc, emc, ept, eptgt);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;

        //    name      v  br  ex_pc         at  atgt        pt  ptgt       if_pc         mux red          bc mc pt  ptgt
        step("idle",    0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h100,      0, 32'h0,       0, 0, 0, 32'h0);
        step("mp1",     1, 1, 32'h40,       1, 32'h80,     0, 32'h0,    32'h40,       1, 32'h80,      0, 0, 0, 32'h0);
        step("sq1",     1, 1, 32'h40,       1, 32'h80,     0, 32'h0,    32'h40,       0, 32'h0,       1, 1, 1, 32'h80);
        step("sq2",     1, 1, 32'h40,       1, 32'h80,     0, 32'h0,    32'h40,       0, 32'h0,       1, 1, 1, 32'h80);
        step("t2",      1, 1, 32'h40,       1, 32'h80,     1, 32'h80,   32'h40,       0, 32'h0,       1, 1, 1, 32'h80);
        step("t3",      1, 1, 32'h40,       1, 32'h80,     1, 32'h80,   32'h40,       0, 32'h0,       2, 1, 1, 32'h80);
        step("t4",      1, 1, 32'h40,       1, 32'h80,     1, 32'h80,   32'h40,       0, 32'h0,       3, 1, 1, 32'h80);
        step("nt1",     1, 1, 32'h40,       0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       4, 1, 1, 32'h80);
        step("nt2",     1, 1, 32'h40,       0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       5, 1, 1, 32'h80);
        step("weak",    0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       6, 1, 0, 32'h80);
        step("wrap",    1, 1, 32'hFFFFFFFC, 0, 32'h0,      1, 32'h10,   32'hFFFFFFFC, 1, 32'h0,       6, 1, 0, 32'h0);
        step("sqA",     0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       7, 2, 0, 32'h80);
        step("sqB",     0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       7, 2, 0, 32'h80);
        step("nobr",    1, 0, 32'h40,       1, 32'h200,    0, 32'h0,    32'h40,       0, 32'h0,       7, 2, 0, 32'h80);
        step("alias",   1, 1, 32'h80,       1, 32'h300,    0, 32'h0,    32'h80,       1, 32'h300,     7, 2, 0, 32'h80);
        step("sqC",     0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       8, 3, 1, 32'h300);

        // Reset mid-squash while EX presents a would-be mispredict.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 32'h40);
        reset_n = 1'b0;
        expect_push("rstsq", 1'b0, 32'h0, 0, 0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        reset_n  = 1'b1;
        ex_valid = 1'b0;

        step("post",    1, 1, 32'h40,       1, 32'h80,     0, 32'h0,    32'h40,       1, 32'h80,      0, 0, 0, 32'h0);
        step("sqD",     0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       1, 1, 1, 32'h80);
        step("sqE",     0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       1, 1, 1, 32'h80);
        step("tgtmis",  1, 1, 32'h40,       1, 32'h90,     1, 32'h80,   32'h40,       1, 32'h90,      1, 1, 1, 32'h80);
        step("final",   0, 0, 32'h0,        0, 32'h0,      0, 32'h0,    32'h40,       0, 32'h0,       2, 2, 1, 32'h90);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
